// File: rtl/poly_voice_alloc.sv
// Polyphonic voice allocator: maps MIDI note/CC events onto a fixed pool of voices
// with retrigger, free-voice preference, oldest-voice stealing and sustain pedal handling.
module poly_voice_alloc #(
    parameter int unsigned VOICES  = 8,
    parameter int unsigned V_WIDTH = 3
) (
    input  logic               reg_clk,
    input  logic               reset_reg_N,
    input  logic               omni,
    input  logic [3:0]         rx_chan,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic [1:0]         ev_type,
    input  logic [3:0]         ev_chan,
    input  logic [6:0]         ev_d1,
    input  logic [6:0]         ev_d2,
    input  logic [VOICES-1:0]  voice_free,
    output logic [VOICES-1:0]  key_on,
    output logic               upd_valid,
    output logic [V_WIDTH-1:0] upd_voice,
    output logic [6:0]         upd_key,
    output logic [6:0]         upd_vel,
    output logic               upd_on,
    output logic [VOICES-1:0]  rel_mask,
    output logic [V_WIDTH:0]   active_keys,
    output logic               sustain
);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_COMMIT} state_t;

    localparam logic [V_WIDTH:0]   MAX_KEYS = (V_WIDTH+1)'(VOICES);
    localparam logic [V_WIDTH-1:0] OLDEST   = V_WIDTH'(VOICES-1);

    state_t             state, state_nx;
    logic               ev_acc;
    logic [1:0]         ev_t_q;
    logic [6:0]         d1_q, d2_q;
    logic [VOICES-1:0]  sustained, key_vld;
    logic [6:0]         key_val [VOICES];
    logic [V_WIDTH-1:0] age     [VOICES];

    logic               is_on, is_off, is_sus_cc, is_ano, sus_nx;
    logic               hold_hit, off_hit, free_hit, idle_hit;
    logic [V_WIDTH-1:0] hold_v, off_v, free_v, idle_v, old_v, alloc_v;
    logic [VOICES-1:0]  sus_rel;
    logic [V_WIDTH:0]   rel_cnt;

    always_comb begin
        state_nx = state;
        ev_ready = 1'b0;
        case (state)
            S_IDLE: begin
                ev_ready = 1'b1;
                if (ev_valid) state_nx = S_LOOKUP;
            end
            S_LOOKUP: state_nx = S_COMMIT;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Voice search runs during LOOKUP; voice_free only matters there because
    // the result is committed on the LOOKUP->COMMIT edge.
    always_comb begin
        is_on     = (ev_t_q == 2'd1) && (d2_q != '0);
        is_off    = (ev_t_q == 2'd0) || ((ev_t_q == 2'd1) && (d2_q == '0));
        is_sus_cc = (ev_t_q == 2'd2) && (d1_q == 7'd64);
        is_ano    = (ev_t_q == 2'd2) && (d1_q == 7'd123);
        sus_nx    = d2_q[6];
        hold_hit  = 1'b0;
        off_hit   = 1'b0;
        free_hit  = 1'b0;
        idle_hit  = 1'b0;
        hold_v    = '0;
        off_v     = '0;
        free_v    = '0;
        idle_v    = '0;
        old_v     = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (!hold_hit && key_on[i] && key_vld[i] && key_val[i] == d1_q) begin
                hold_hit = 1'b1;
                hold_v   = V_WIDTH'(i);
            end
            if (!off_hit && key_on[i] && !sustained[i] && key_vld[i] && key_val[i] == d1_q) begin
                off_hit = 1'b1;
                off_v   = V_WIDTH'(i);
            end
            if (!free_hit && !key_on[i] && !sustained[i] && voice_free[i]) begin
                free_hit = 1'b1;
                free_v   = V_WIDTH'(i);
            end
            if (!idle_hit && !key_on[i]) begin
                idle_hit = 1'b1;
                idle_v   = V_WIDTH'(i);
            end
            if (age[i] == OLDEST) old_v = V_WIDTH'(i);
        end
        alloc_v = hold_hit ? hold_v : free_hit ? free_v : idle_hit ? idle_v : old_v;
        sus_rel = (sustain && !sus_nx) ? sustained : '0;
        rel_cnt = (V_WIDTH+1)'($countones(sus_rel));
    end

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state       <= S_IDLE;
            ev_acc      <= 1'b0;
            ev_t_q      <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            key_on      <= '0;
            sustained   <= '0;
            key_vld     <= '0;
            sustain     <= 1'b0;
            active_keys <= '0;
            upd_valid   <= 1'b0;
            upd_voice   <= '0;
            upd_key     <= '0;
            upd_vel     <= '0;
            upd_on      <= 1'b0;
            rel_mask    <= '0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                key_val[i] <= '0;
                age[i]     <= V_WIDTH'(VOICES - 1 - i);
            end
        end else begin
            state     <= state_nx;
            upd_valid <= 1'b0;
            rel_mask  <= '0;
            if (state == S_IDLE && ev_valid) begin
                ev_acc <= omni || (ev_chan == rx_chan);
                ev_t_q <= ev_type;
                d1_q   <= ev_d1;
                d2_q   <= ev_d2;
            end
            if (state == S_LOOKUP && ev_acc) begin
                if (is_on) begin
                    key_on[alloc_v]    <= 1'b1;
                    key_vld[alloc_v]   <= 1'b1;
                    key_val[alloc_v]   <= d1_q;
                    sustained[alloc_v] <= 1'b0;
                    for (int unsigned i = 0; i < VOICES; i++)
                        if (age[i] < age[alloc_v]) age[i] <= age[i] + 1'b1;
                    age[alloc_v] <= '0;
                    upd_valid <= 1'b1;
                    upd_voice <= alloc_v;
                    upd_key   <= d1_q;
                    upd_vel   <= d2_q;
                    upd_on    <= 1'b1;
                    if (!hold_hit && (free_hit || idle_hit) && active_keys < MAX_KEYS)
                        active_keys <= active_keys + 1'b1;
                end else if (is_off && off_hit) begin
                    if (sustain) begin
                        sustained[off_v] <= 1'b1;
                    end else begin
                        key_on[off_v] <= 1'b0;
                        upd_valid     <= 1'b1;
                        upd_voice     <= off_v;
                        upd_key       <= d1_q;
                        upd_vel       <= d2_q;
                        upd_on        <= 1'b0;
                        if (active_keys != '0) active_keys <= active_keys - 1'b1;
                    end
                end else if (is_sus_cc) begin
                    sustain     <= sus_nx;
                    key_on      <= key_on & ~sus_rel;
                    sustained   <= sustained & ~sus_rel;
                    rel_mask    <= sus_rel;
                    active_keys <= (active_keys > rel_cnt) ? active_keys - rel_cnt : '0;
                end else if (is_ano) begin
                    key_on      <= '0;
                    sustained   <= '0;
                    key_vld     <= '0;
                    rel_mask    <= key_on;
                    active_keys <= '0;
                end
            end
        end
    end

endmodule
